// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipelined core. It resolves
// load-use hazards, taken branches/jumps from Execute, multi-cycle data-memory
// accesses (with a timeout that latches an error), and a post-reset pipeline
// clear. Saturating counters track stall cycles and branch-induced flushes.
//
// Ports
//   clk, rst            : core clock, asynchronous active-high reset
//   Rs1D, Rs2D          : source registers of the Decode instruction
//   RdE, RegWriteE      : destination / write enable of the Execute instruction
//   ResultSrcE          : Execute result source (2'b01 = load)
//   PCSrcE              : taken branch or jump resolved in Execute
//   MemReqM, MemReadyM  : Memory-stage access request / completion
//   StallF..StallM      : hold PC, F/D, D/E, E/M registers
//   FlushD, FlushE      : clear F/D, D/E registers
//   FlushW              : clear M/W register (bubble into Writeback)
//   MemError            : sticky memory-timeout flag
//   StallCycles         : saturating count of cycles with StallF=1
//   FlushEvents         : saturating count of branch-induced flushes
//
// All stall/flush outputs are Mealy (combinational from state and inputs);
// state, counters and MemError are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdE,
    input  logic                 RegWriteE,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemError,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] FlushEvents
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((INIT_CYCLES > 1) ? INIT_CYCLES - 1 : 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 1) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [INIT_W-1:0]   init_cnt_reg, init_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                mem_error_reg, mem_error_next;
    logic [CNT_WIDTH-1:0] stall_cnt_reg, flush_cnt_reg;

    logic load_use;
    logic mem_wait;
    logic run_rules;     // branch / load-use resolution applies this cycle
    logic branch_flush;  // a branch flush is actually issued this cycle

    // Load in Execute whose destination feeds the Decode instruction; x0 never
    // creates a dependency.
    assign load_use = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = MemReqM && !MemReadyM;

    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        mem_error_next = mem_error_reg;
        run_rules      = 1'b0;
        branch_flush   = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;

        unique case (state_reg)
            S_INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (init_cnt_reg == INIT_LAST) begin
                    state_next    = S_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end

            S_RUN: begin
                if (mem_wait) begin
                    // Freeze everything up to E/M and send a bubble to Writeback.
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    wait_cnt_next = WAIT_W'(1);
                    // A one-cycle timeout expires on the very first wait cycle.
                    if (MEM_TIMEOUT <= 1) begin
                        state_next     = S_ERROR;
                        mem_error_next = 1'b1;
                    end else begin
                        state_next = S_MEM_WAIT;
                    end
                end else begin
                    run_rules = 1'b1;
                end
            end

            S_MEM_WAIT: begin
                if (!MemReadyM) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                    // wait_cnt_reg counts completed wait cycles, so this cycle
                    // is the MEM_TIMEOUT-th one when it equals MEM_TIMEOUT-1.
                    if (wait_cnt_reg >= WAIT_LAST) begin
                        state_next     = S_ERROR;
                        mem_error_next = 1'b1;
                    end
                end else begin
                    // Access completes: release stalls now and resolve the
                    // Execute-stage hazards as in RUN.
                    run_rules     = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = S_RUN;
                end
            end

            S_ERROR: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end

            default: begin
                state_next = S_INIT;
            end
        endcase

        // Branch beats load-use: the dependent instruction is squashed anyway.
        if (run_rules) begin
            if (PCSrcE) begin
                FlushD       = 1'b1;
                FlushE       = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_INIT;
            init_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            mem_error_reg <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_error_reg <= mem_error_next;
            if (StallF && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (branch_flush && (flush_cnt_reg != {CNT_WIDTH{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign MemError    = mem_error_reg;
    assign StallCycles = stall_cnt_reg;
    assign FlushEvents = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipeline_hazard_ctrl. Two instances share the inputs:
// dut (16-bit counters) and dut_sat (4-bit counters, saturation check). Both
// use INIT_CYCLES=2 and MEM_TIMEOUT=4. Control outputs are packed as
// {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, RdE = '0;
    logic       RegWriteE = 1'b0;
    logic [1:0] ResultSrcE = '0;
    logic       PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;

    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemError;
    logic [15:0] StallCycles, FlushEvents;
    logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW, s_MemError;
    logic [3:0]  s_StallCycles, s_FlushEvents;

    logic [6:0] ctl, s_ctl;
    assign ctl   = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    assign s_ctl = {s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW};

    localparam logic [6:0] C_INIT   = 7'b1000110;
    localparam logic [6:0] C_LU     = 7'b1100010;
    localparam logic [6:0] C_BR     = 7'b0000110;
    localparam logic [6:0] C_MEM    = 7'b1111001;
    localparam logic [6:0] C_NONE   = 7'b0000000;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemError(MemError),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents)
    );

    pipeline_hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW), .MemError(s_MemError),
        .StallCycles(s_StallCycles), .FlushEvents(s_FlushEvents)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; RdE = '0; RegWriteE = 1'b0; ResultSrcE = '0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if (ctl !== C_INIT) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_INIT); else passed++;
        total++; if (StallCycles !== 16'd0) $display("FAIL reset_stallcnt got=%0d exp=0", StallCycles); else passed++;
        total++; if (FlushEvents !== 16'd0) $display("FAIL reset_flushcnt got=%0d exp=0", FlushEvents); else passed++;
        total++; if (MemError !== 1'b0) $display("FAIL reset_memerr got=%b exp=0", MemError); else passed++;
        rst = 1'b0;
        #1;
        total++; if (ctl !== C_INIT) $display("FAIL init_c0 got=%b exp=%b", ctl, C_INIT); else passed++;
        tick();
        total++; if (ctl !== C_INIT) $display("FAIL init_c1 got=%b exp=%b", ctl, C_INIT); else passed++;
        tick();
        total++; if (ctl !== C_NONE) $display("FAIL init_run got=%b exp=%b", ctl, C_NONE); else passed++;
        total++; if (StallCycles !== 16'd2) $display("FAIL init_stallcnt got=%0d exp=2", StallCycles); else passed++;
        $display("test_reset done: StallCycles=%0d", StallCycles);
    endtask

    task automatic test_load_use();
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; Rs1D = 5'd3;
        #1;
        total++; if (ctl !== C_LU) $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); else passed++;
        tick();
        total++; if (StallCycles !== 16'd3) $display("FAIL lu_stallcnt got=%0d exp=3", StallCycles); else passed++;
        RdE = 5'd0; Rs2D = 5'd0; Rs1D = 5'd0;
        #1;
        total++; if (ctl !== C_NONE) $display("FAIL lu_x0 got=%b exp=%b", ctl, C_NONE); else passed++;
        RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd1; ResultSrcE = 2'b00;
        #1;
        total++; if (ctl !== C_NONE) $display("FAIL lu_notload got=%b exp=%b", ctl, C_NONE); else passed++;
        ResultSrcE = 2'b01;
        #1;
        total++; if (ctl !== C_LU) $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); else passed++;
        tick();
        $display("test_load_use done: StallCycles=%0d", StallCycles);
    endtask

    task automatic test_branch();
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
        #1;
        total++; if (ctl !== C_BR) $display("FAIL br_over_lu got=%b exp=%b", ctl, C_BR); else passed++;
        tick();
        total++; if (FlushEvents !== 16'd1) $display("FAIL br_flushcnt got=%0d exp=1", FlushEvents); else passed++;
        total++; if (StallCycles !== 16'd4) $display("FAIL br_stallcnt got=%0d exp=4", StallCycles); else passed++;
        clear_inputs();
        $display("test_branch done: FlushEvents=%0d", FlushEvents);
    endtask

    task automatic test_mem_wait();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl !== C_MEM) $display("FAIL mem_wait%0d got=%b exp=%b", i, ctl, C_MEM); else passed++;
            tick();
        end
        MemReadyM = 1'b1;
        #1;
        total++; if (ctl !== C_NONE) $display("FAIL mem_release got=%b exp=%b", ctl, C_NONE); else passed++;
        tick();
        MemReqM = 1'b0; MemReadyM = 1'b0;
        #1;
        total++; if (ctl !== C_NONE) $display("FAIL mem_back_run got=%b exp=%b", ctl, C_NONE); else passed++;
        total++; if (StallCycles !== 16'd7) $display("FAIL mem_stallcnt got=%0d exp=7", StallCycles); else passed++;
        $display("test_mem_wait done: StallCycles=%0d", StallCycles);
    endtask

    task automatic test_back_to_back();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        #1;
        total++; if (ctl !== C_MEM) $display("FAIL b2b_wait got=%b exp=%b", ctl, C_MEM); else passed++;
        tick();
        MemReadyM = 1'b1; PCSrcE = 1'b1;
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
        #1;
        total++; if (ctl !== C_BR) $display("FAIL b2b_release_br got=%b exp=%b", ctl, C_BR); else passed++;
        tick();
        clear_inputs();
        #1;
        total++; if (FlushEvents !== 16'd2) $display("FAIL b2b_flushcnt got=%0d exp=2", FlushEvents); else passed++;
        total++; if (StallCycles !== 16'd8) $display("FAIL b2b_stallcnt got=%0d exp=8", StallCycles); else passed++;
        total++; if (ctl !== C_NONE) $display("FAIL b2b_idle got=%b exp=%b", ctl, C_NONE); else passed++;
        $display("test_back_to_back done: FlushEvents=%0d", FlushEvents);
    endtask

    task automatic test_timeout_priority();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (3) tick();
        MemReadyM = 1'b1;
        #1;
        total++; if (ctl !== C_NONE) $display("FAIL tprio_release got=%b exp=%b", ctl, C_NONE); else passed++;
        tick();
        clear_inputs();
        #1;
        total++; if (MemError !== 1'b0) $display("FAIL tprio_memerr got=%b exp=0", MemError); else passed++;
        total++; if (ctl !== C_NONE) $display("FAIL tprio_run got=%b exp=%b", ctl, C_NONE); else passed++;
        total++; if (StallCycles !== 16'd11) $display("FAIL tprio_stallcnt got=%0d exp=11", StallCycles); else passed++;
        $display("test_timeout_priority done: StallCycles=%0d", StallCycles);
    endtask

    task automatic test_timeout();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (3) tick();
        total++; if (MemError !== 1'b0) $display("FAIL tout_early got=%b exp=0", MemError); else passed++;
        tick();
        total++; if (MemError !== 1'b1) $display("FAIL tout_set got=%b exp=1", MemError); else passed++;
        total++; if (StallCycles !== 16'd15) $display("FAIL tout_stallcnt got=%0d exp=15", StallCycles); else passed++;
        MemReqM = 1'b0; MemReadyM = 1'b1;
        #1;
        total++; if (ctl !== C_MEM) $display("FAIL tout_err_ctl got=%b exp=%b", ctl, C_MEM); else passed++;
        tick();
        total++; if (MemError !== 1'b1) $display("FAIL tout_sticky got=%b exp=1", MemError); else passed++;
        total++; if (ctl !== C_MEM) $display("FAIL tout_held got=%b exp=%b", ctl, C_MEM); else passed++;
        $display("test_timeout done: MemError=%b", MemError);
    endtask

    task automatic test_saturation();
        total++; if (s_StallCycles !== 4'd15) $display("FAIL sat_reach got=%0d exp=15", s_StallCycles); else passed++;
        repeat (5) tick();
        total++; if (s_StallCycles !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", s_StallCycles); else passed++;
        total++; if (StallCycles !== 16'd21) $display("FAIL sat_wide got=%0d exp=21", StallCycles); else passed++;
        total++; if (s_FlushEvents !== 4'd2) $display("FAIL sat_flushcnt got=%0d exp=2", s_FlushEvents); else passed++;
        $display("test_saturation done: narrow=%0d wide=%0d", s_StallCycles, StallCycles);
    endtask

    task automatic test_rst_clear();
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        total++; if (MemError !== 1'b0) $display("FAIL rst_memerr got=%b exp=0", MemError); else passed++;
        total++; if (s_MemError !== 1'b0) $display("FAIL rst_memerr_sat got=%b exp=0", s_MemError); else passed++;
        total++; if (ctl !== C_INIT) $display("FAIL rst_ctl got=%b exp=%b", ctl, C_INIT); else passed++;
        total++; if (s_ctl !== C_INIT) $display("FAIL rst_ctl_sat got=%b exp=%b", s_ctl, C_INIT); else passed++;
        total++; if (StallCycles !== 16'd0) $display("FAIL rst_stallcnt got=%0d exp=0", StallCycles); else passed++;
        total++; if (FlushEvents !== 16'd0) $display("FAIL rst_flushcnt got=%0d exp=0", FlushEvents); else passed++;
        tick();
        rst = 1'b0;
        tick();
        total++; if (ctl !== C_INIT) $display("FAIL rst_init got=%b exp=%b", ctl, C_INIT); else passed++;
        tick();
        total++; if (ctl !== C_NONE) $display("FAIL rst_run got=%b exp=%b", ctl, C_NONE); else passed++;
        total++; if (StallCycles !== 16'd2) $display("FAIL rst_init_cnt got=%0d exp=2", StallCycles); else passed++;
        $display("test_rst_clear done: StallCycles=%0d", StallCycles);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout_priority();
        test_timeout();
        test_saturation();
        test_rst_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
